// File: rtl/timestamp_ctr.sv
// timestamp_ctr -- free-running timestamp counter on a 10 Hz tick.
//
// A prescaler divides enabled CLK_10HZ ticks by PRESCALE; each wrap of the
// prescaler is a count event that advances TIMESTAMP. Overflow either wraps
// to zero or saturates at all-ones (SAT_MODE) and sets the sticky WRAP flag.
// A two-state snapshot handshake captures TIMESTAMP on request and holds it
// until acknowledged.
//
// Parameters:
//   WIDTH    counter/timestamp width, 8..48
//   PRESCALE enabled ticks per count event, 1..65535
//   SAT_MODE 0 = wrap at overflow, 1 = saturate at all-ones
// Ports:
//   CLK_10HZ   in   10 Hz clock, all state changes on rising edge
//   RESET      in   asynchronous active-high reset
//   EN         in   count enable
//   LOAD       in   synchronous preset strobe (priority over counting)
//   LOAD_VAL   in   preset value
//   SNAP_REQ   in   snapshot request
//   SNAP_ACK   in   snapshot consumed
//   WRAP_CLR   in   clears WRAP
//   TIMESTAMP  out  live count
//   SNAP_VAL   out  captured timestamp
//   SNAP_VALID out  SNAP_VAL holds a valid snapshot
//   WRAP       out  sticky overflow flag
module timestamp_ctr #(
   parameter int unsigned WIDTH    = 32,
   parameter int unsigned PRESCALE = 1,
   parameter int unsigned SAT_MODE = 0
) (
   input  logic             CLK_10HZ,
   input  logic             RESET,
   input  logic             EN,
   input  logic             LOAD,
   input  logic [WIDTH-1:0] LOAD_VAL,
   input  logic             SNAP_REQ,
   input  logic             SNAP_ACK,
   input  logic             WRAP_CLR,
   output logic [WIDTH-1:0] TIMESTAMP,
   output logic [WIDTH-1:0] SNAP_VAL,
   output logic             SNAP_VALID,
   output logic             WRAP
);

   localparam logic [15:0] PRE_LAST = 16'(PRESCALE - 1);

   typedef enum logic {
      SNAP_IDLE = 1'b0,
      SNAP_HOLD = 1'b1
   } snap_state_t;

   logic [15:0]      pre_cnt;
   logic [WIDTH-1:0] ts_q;
   logic [WIDTH-1:0] snap_q;
   logic             wrap_q;
   logic             count_evt;
   logic             at_max;
   logic             wrap_set;
   snap_state_t      snap_state;
   snap_state_t      snap_next;
   logic             snap_capture;

   // LOAD suppresses the count event even when the prescaler is at its end.
   assign count_evt = EN && !LOAD && (pre_cnt == PRE_LAST);
   assign at_max    = &ts_q;
   assign wrap_set  = count_evt && at_max;

   // Prescaler and live counter
   always_ff @(posedge CLK_10HZ or posedge RESET) begin
      if (RESET) begin
         pre_cnt <= '0;
         ts_q    <= '0;
      end else if (LOAD) begin
         pre_cnt <= '0;
         ts_q    <= LOAD_VAL;
      end else if (EN) begin
         if (pre_cnt == PRE_LAST) begin
            pre_cnt <= '0;
            if (!at_max)
               ts_q <= ts_q + WIDTH'(1);
            else if (SAT_MODE == 0)
               ts_q <= '0;
         end else begin
            pre_cnt <= pre_cnt + 16'd1;
         end
      end
   end

   // Sticky overflow flag; a coincident set beats the clear.
   always_ff @(posedge CLK_10HZ or posedge RESET) begin
      if (RESET)
         wrap_q <= 1'b0;
      else if (wrap_set)
         wrap_q <= 1'b1;
      else if (WRAP_CLR)
         wrap_q <= 1'b0;
   end

   // Snapshot FSM: state register
   always_ff @(posedge CLK_10HZ or posedge RESET) begin
      if (RESET)
         snap_state <= SNAP_IDLE;
      else
         snap_state <= snap_next;
   end

   // Snapshot FSM: next state; in HOLD the request is ignored, only ACK matters.
   always_comb begin
      snap_next    = snap_state;
      snap_capture = 1'b0;
      case (snap_state)
         SNAP_IDLE: begin
            if (SNAP_REQ) begin
               snap_next    = SNAP_HOLD;
               snap_capture = 1'b1;
            end
         end
         SNAP_HOLD: begin
            if (SNAP_ACK)
               snap_next = SNAP_IDLE;
         end
         default: snap_next = SNAP_IDLE;
      endcase
   end

   // Captures the pre-edge counter value, so a coincident LOAD or count
   // event is not visible in the snapshot.
   always_ff @(posedge CLK_10HZ or posedge RESET) begin
      if (RESET)
         snap_q <= '0;
      else if (snap_capture)
         snap_q <= ts_q;
   end

   assign TIMESTAMP  = ts_q;
   assign SNAP_VAL   = snap_q;
   assign SNAP_VALID = (snap_state == SNAP_HOLD);
   assign WRAP       = wrap_q;

endmodule

// File: tb/tb_timestamp_ctr.sv
// tb_timestamp_ctr -- scoreboard bench for timestamp_ctr.
// Four instances share stimulus: 8-bit wrap, 16-bit prescale-10,
// 8-bit saturating, and a 16-bit main instance.
module tb_timestamp_ctr;

   typedef struct packed {
      logic [15:0] ts;
      logic [15:0] pre;
      logic [15:0] snap;
      logic        valid;
      logic        wrap;
   } m_t;

   logic        clk;
   logic        rst;
   logic        en;
   logic        load;
   logic [15:0] load_val;
   logic        snap_req;
   logic        snap_ack;
   logic        wrap_clr;

   logic [7:0]  ts_a, sv_a, ts_s, sv_s;
   logic [15:0] ts_p, sv_p, ts_d, sv_d;
   logic        vl_a, wr_a, vl_p, wr_p, vl_s, wr_s, vl_d, wr_d;

   int unsigned n_checks;
   int unsigned n_errors;
   m_t          mdl[4];
   m_t          sb[$];

   timestamp_ctr #(.WIDTH(8), .PRESCALE(1), .SAT_MODE(0)) u_wrap (
      .CLK_10HZ(clk), .RESET(rst), .EN(en), .LOAD(load), .LOAD_VAL(load_val[7:0]),
      .SNAP_REQ(snap_req), .SNAP_ACK(snap_ack), .WRAP_CLR(wrap_clr),
      .TIMESTAMP(ts_a), .SNAP_VAL(sv_a), .SNAP_VALID(vl_a), .WRAP(wr_a));

   timestamp_ctr #(.WIDTH(16), .PRESCALE(10), .SAT_MODE(0)) u_pre (
      .CLK_10HZ(clk), .RESET(rst), .EN(en), .LOAD(load), .LOAD_VAL(load_val),
      .SNAP_REQ(snap_req), .SNAP_ACK(snap_ack), .WRAP_CLR(wrap_clr),
      .TIMESTAMP(ts_p), .SNAP_VAL(sv_p), .SNAP_VALID(vl_p), .WRAP(wr_p));

   timestamp_ctr #(.WIDTH(8), .PRESCALE(1), .SAT_MODE(1)) u_sat (
      .CLK_10HZ(clk), .RESET(rst), .EN(en), .LOAD(load), .LOAD_VAL(load_val[7:0]),
      .SNAP_REQ(snap_req), .SNAP_ACK(snap_ack), .WRAP_CLR(wrap_clr),
      .TIMESTAMP(ts_s), .SNAP_VAL(sv_s), .SNAP_VALID(vl_s), .WRAP(wr_s));

   timestamp_ctr #(.WIDTH(16), .PRESCALE(1), .SAT_MODE(0)) dut (
      .CLK_10HZ(clk), .RESET(rst), .EN(en), .LOAD(load), .LOAD_VAL(load_val),
      .SNAP_REQ(snap_req), .SNAP_ACK(snap_ack), .WRAP_CLR(wrap_clr),
      .TIMESTAMP(ts_d), .SNAP_VAL(sv_d), .SNAP_VALID(vl_d), .WRAP(wr_d));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [47:0] act, input logic [47:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, act, exp);
      end
   endtask

   function automatic m_t obs(input int i);
      m_t o;
      o = '0;
      case (i)
         0: o = '{ts: {8'h0, ts_a}, pre: u_wrap.pre_cnt, snap: {8'h0, sv_a}, valid: vl_a, wrap: wr_a};
         1: o = '{ts: ts_p, pre: u_pre.pre_cnt, snap: sv_p, valid: vl_p, wrap: wr_p};
         2: o = '{ts: {8'h0, ts_s}, pre: u_sat.pre_cnt, snap: {8'h0, sv_s}, valid: vl_s, wrap: wr_s};
         default: o = '{ts: ts_d, pre: dut.pre_cnt, snap: sv_d, valid: vl_d, wrap: wr_d};
      endcase
      return o;
   endfunction

   // Reference behaviour of one instance for one rising edge.
   function automatic m_t step(input m_t c, input int i);
      m_t          n;
      logic [15:0] mask;
      int          p;
      bit          sat;
      bit          evt;
      n    = c;
      mask = (i == 0 || i == 2) ? 16'h00FF : 16'hFFFF;
      p    = (i == 1) ? 10 : 1;
      sat  = (i == 2);
      evt  = 0;
      if (load) begin
         n.ts  = load_val & mask;
         n.pre = 16'd0;
      end else if (en) begin
         if (int'(c.pre) == p - 1) begin
            n.pre = 16'd0;
            evt   = 1;
         end else begin
            n.pre = c.pre + 16'd1;
         end
      end
      if (evt) begin
         if (c.ts == mask) n.ts = sat ? mask : 16'd0;
         else              n.ts = c.ts + 16'd1;
      end
      if (evt && c.ts == mask) n.wrap = 1'b1;
      else if (wrap_clr)       n.wrap = 1'b0;
      if (!c.valid) begin
         if (snap_req) begin
            n.valid = 1'b1;
            n.snap  = c.ts;
         end
      end else if (snap_ack) begin
         n.valid = 1'b0;
      end
      return n;
   endfunction

   // Push expectations for this edge, clock, then pop and compare.
   task automatic tick();
      m_t e;
      m_t o;
      for (int i = 0; i < 4; i++) begin
         mdl[i] = step(mdl[i], i);
         sb.push_back(mdl[i]);
      end
      @(posedge clk);
      #1;
      for (int i = 0; i < 4; i++) begin
         e = sb.pop_front();
         o = obs(i);
         chk($sformatf("i%0d_ts", i),    48'(o.ts),    48'(e.ts));
         chk($sformatf("i%0d_pre", i),   48'(o.pre),   48'(e.pre));
         chk($sformatf("i%0d_snap", i),  48'(o.snap),  48'(e.snap));
         chk($sformatf("i%0d_valid", i), 48'(o.valid), 48'(e.valid));
         chk($sformatf("i%0d_wrap", i),  48'(o.wrap),  48'(e.wrap));
      end
   endtask

   task automatic check_zero(input string tag);
      m_t o;
      for (int i = 0; i < 4; i++) begin
         o = obs(i);
         chk($sformatf("%s_i%0d_ts", tag, i),    48'(o.ts),    48'h0);
         chk($sformatf("%s_i%0d_pre", tag, i),   48'(o.pre),   48'h0);
         chk($sformatf("%s_i%0d_snap", tag, i),  48'(o.snap),  48'h0);
         chk($sformatf("%s_i%0d_valid", tag, i), 48'(o.valid), 48'h0);
         chk($sformatf("%s_i%0d_wrap", tag, i),  48'(o.wrap),  48'h0);
         mdl[i] = '0;
      end
   endtask

   // Called at posedge+1: asserts reset mid-period and releases before the next edge.
   task automatic do_reset(input string tag);
      #2;
      rst = 1'b1;
      #1;
      check_zero(tag);
      #1;
      rst = 1'b0;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      n_checks = 0;
      n_errors = 0;
      rst = 1'b1; en = 1'b0; load = 1'b0; load_val = '0;
      snap_req = 1'b0; snap_ack = 1'b0; wrap_clr = 1'b0;
      #2;
      check_zero("por");
      rst = 1'b0;
      tick();

      // 8-bit wrap over 260 edges
      do_reset("rstA");
      en = 1'b1;
      for (int i = 1; i <= 260; i++) begin
         tick();
         if (i == 255) begin
            chk("A_ts255", 48'(ts_a), 48'hFF);
            chk("A_wrap255", 48'(wr_a), 48'h0);
         end
         if (i == 256) begin
            chk("A_ts256", 48'(ts_a), 48'h0);
            chk("A_wrap256", 48'(wr_a), 48'h1);
         end
      end
      chk("A_ts_end", 48'(ts_a), 48'h4);
      chk("A_wrap_end", 48'(wr_a), 48'h1);

      // Prescale 10: first count needs 10 edges; 25 edges -> 2 counts, PRE=5
      do_reset("rstB");
      en = 1'b1;
      for (int i = 1; i <= 25; i++) begin
         tick();
         if (i == 9)  chk("B_ts9", 48'(ts_p), 48'h0);
         if (i == 10) chk("B_ts10", 48'(ts_p), 48'h1);
      end
      chk("B_ts25", 48'(ts_p), 48'h2);
      chk("B_pre25", 48'(u_pre.pre_cnt), 48'h5);
      en = 1'b0;
      repeat (5) tick();
      chk("B_ts_hold", 48'(ts_p), 48'h2);
      chk("B_pre_hold", 48'(u_pre.pre_cnt), 48'h5);
      en = 1'b1;
      repeat (5) tick();
      chk("B_ts_resume", 48'(ts_p), 48'h3);
      chk("B_pre_resume", 48'(u_pre.pre_cnt), 48'h0);

      // Saturation
      do_reset("rstC");
      en = 1'b0; load_val = 16'h00FE; load = 1'b1;
      tick();
      load = 1'b0;
      chk("C_load", 48'(ts_s), 48'hFE);
      en = 1'b1;
      repeat (3) tick();
      chk("C_sat_ts", 48'(ts_s), 48'hFF);
      chk("C_sat_wrap", 48'(wr_s), 48'h1);
      en = 1'b0; wrap_clr = 1'b1;
      tick();
      wrap_clr = 1'b0;
      chk("C_clr", 48'(wr_s), 48'h0);
      en = 1'b1;
      tick();
      chk("C_reset_ts", 48'(ts_s), 48'hFF);
      chk("C_reset_wrap", 48'(wr_s), 48'h1);
      en = 1'b1; wrap_clr = 1'b1;
      tick();
      wrap_clr = 1'b0;
      chk("C_set_wins", 48'(wr_s), 48'h1);

      // LOAD with EN beats counting and clears PRE
      do_reset("rstD");
      en = 1'b1;
      repeat (3) tick();
      load_val = 16'h1234; load = 1'b1;
      tick();
      load = 1'b0;
      chk("D_load_ts", 48'(ts_d), 48'h1234);
      chk("D_load_pre", 48'(dut.pre_cnt), 48'h0);
      chk("D_load_pre10", 48'(u_pre.pre_cnt), 48'h0);
      tick();
      chk("D_after", 48'(ts_d), 48'h1235);

      // Snapshot handshake
      do_reset("rstE");
      en = 1'b0; load_val = 16'h0010; load = 1'b1;
      tick();
      load = 1'b0;
      en = 1'b1; snap_req = 1'b1;
      tick();
      chk("E_snap", 48'(sv_d), 48'h10);
      chk("E_ts", 48'(ts_d), 48'h11);
      chk("E_valid", 48'(vl_d), 48'h1);
      tick();
      chk("E_req2_snap", 48'(sv_d), 48'h10);
      snap_req = 1'b0; en = 1'b0; snap_ack = 1'b1;
      tick();
      chk("E_ack", 48'(vl_d), 48'h0);
      tick();
      chk("E_ack_idle", 48'(vl_d), 48'h0);
      snap_ack = 1'b0; snap_req = 1'b1;
      tick();
      chk("E_cap2", 48'(sv_d), 48'h12);
      snap_ack = 1'b1; en = 1'b1;
      tick();
      chk("E_reqack_valid", 48'(vl_d), 48'h0);
      chk("E_reqack_snap", 48'(sv_d), 48'h12);
      snap_ack = 1'b0; en = 1'b0; load = 1'b1; load_val = 16'h0055;
      tick();
      chk("E_load_snap", 48'(sv_d), 48'h13);
      chk("E_load_ts", 48'(ts_d), 48'h55);

      // Reset mid-period while in HOLD with WRAP set
      snap_req = 1'b0; load_val = 16'hFFFF;
      tick();
      load = 1'b0; en = 1'b1;
      tick();
      en = 1'b0;
      chk("F_wrap", 48'(wr_d), 48'h1);
      chk("F_hold", 48'(vl_d), 48'h1);
      #3;
      rst = 1'b1;
      #1;
      check_zero("F_async");
      #1;
      rst = 1'b0;
      tick();
      chk("F_no_snap", 48'(vl_d), 48'h0);
      snap_req = 1'b1;
      tick();
      snap_req = 1'b0;
      chk("F_new_snap", 48'(vl_d), 48'h1);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
